fetch_predict_unit: RTL and testbench

Parametrised next-generation fetch PC generator for the in-order pipeline's IF stage. It holds the fetch PC and predicts the next PC each cycle with three structures: a gshare direction predictor, a tagged direct-mapped BTB that stores branch kind, and a speculative return-address stack (RAS) with committed-state repair. EX resolves branches and feeds them back to train the structures and to redirect fetch; the unit also exposes performance counters.

---
 rtl/fetch_predict_unit_pkg.sv | 18 +
 rtl/fetch_predict_unit_ras.sv | 65 ++++++
 rtl/fetch_predict_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_predict_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_predict_unit_pkg.sv
// Shared types and constants for the fetch PC generator and its branch predictors.
package fetch_pkg;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JUMP = 2'd1,
      BR_CALL = 2'd2,
      BR_RET  = 2'd3
   } br_kind_e;

   localparam logic [1:0] PHT_RESET = 2'b01;

   function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'b01;
      else    return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/fetch_predict_unit_ras.sv
// Circular return-address stack; overwrites the oldest entry when full and can be
// bulk-loaded from another stack's next state.
module ras_stack #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                push,
   input  logic                                pop,
   input  logic [XLEN-1:0]                     push_data,
   input  logic                                load,
   input  logic [DEPTH-1:0][XLEN-1:0]          load_entries,
   input  logic [$clog2(DEPTH)-1:0]            load_ptr,
   input  logic [$clog2(DEPTH):0]              load_count,
   output logic [XLEN-1:0]                     top,
   output logic [$clog2(DEPTH):0]              count,
   output logic [DEPTH-1:0][XLEN-1:0]          nxt_entries,
   output logic [$clog2(DEPTH)-1:0]            nxt_ptr,
   output logic [$clog2(DEPTH):0]              nxt_count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DEPTH-1:0][XLEN-1:0] r_entries;
   logic [PW-1:0]              r_ptr;
   logic [CW-1:0]              r_count;
   logic [PW-1:0]              w_ptr_inc;

   // r_ptr addresses the current top; a push advances it before writing
   always_comb begin
      nxt_entries = r_entries;
      nxt_ptr     = r_ptr;
      nxt_count   = r_count;
      w_ptr_inc   = r_ptr + 1'b1;
      if (load) begin
         nxt_entries = load_entries;
         nxt_ptr     = load_ptr;
         nxt_count   = load_count;
      end else if (push) begin
         nxt_ptr              = w_ptr_inc;
         nxt_entries[w_ptr_inc] = push_data;
         if (r_count != CW'(DEPTH)) nxt_count = r_count + 1'b1;
      end else if (pop && r_count != '0) begin
         nxt_ptr   = r_ptr - 1'b1;
         nxt_count = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entries <= '0;
         r_ptr     <= '0;
         r_count   <= '0;
      end else begin
         r_entries <= nxt_entries;
         r_ptr     <= nxt_ptr;
         r_count   <= nxt_count;
      end
   end

   assign top   = r_entries[r_ptr];
   assign count = r_count;

endmodule

// File: rtl/fetch_predict_unit.sv
// IF-stage next-PC generator: gshare direction, tagged direct-mapped BTB with kind,
// speculative RAS repaired from a committed RAS on redirect, plus perf counters.
module fetch_predict_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN        = 32,
   parameter int unsigned      PHT_ENTRIES = 256,
   parameter int unsigned      BTB_ENTRIES = 64,
   parameter int unsigned      RAS_DEPTH   = 8,
   parameter logic [XLEN-1:0]  RESET_PC    = '0,
   parameter int unsigned      CNT_W       = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           stall,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   input  logic                           upd_valid,
   input  logic [XLEN-1:0]                upd_pc,
   input  logic [XLEN-1:0]                upd_target,
   input  logic                           upd_taken,
   input  logic [1:0]                     upd_kind,
   input  logic [$clog2(PHT_ENTRIES)-1:0] upd_pht_idx,
   input  logic                           upd_mispredict,
   output logic                           f_valid,
   output logic [XLEN-1:0]                f_pc,
   output logic                           f_pred_taken,
   output logic [XLEN-1:0]                f_pred_target,
   output logic [$clog2(PHT_ENTRIES)-1:0] f_pht_idx,
   output logic                           f_btb_hit,
   output logic [1:0]                     f_kind,
   output logic [CNT_W-1:0]               perf_lookups,
   output logic [CNT_W-1:0]               perf_btb_hits,
   output logic [CNT_W-1:0]               perf_mispredicts
);
   localparam int unsigned G  = $clog2(PHT_ENTRIES);
   localparam int unsigned B  = $clog2(BTB_ENTRIES);
   localparam int unsigned TW = XLEN - B - 2;
   localparam int unsigned PW = $clog2(RAS_DEPTH);

   typedef struct packed {
      logic            valid;
      logic [TW-1:0]   tag;
      logic [XLEN-1:0] target;
      br_kind_e        kind;
   } btb_entry_t;

   logic                r_valid;
   logic [XLEN-1:0]     r_pc;
   logic [G-1:0]        r_ghr;
   logic [1:0]          r_pht [PHT_ENTRIES];
   btb_entry_t          r_btb [BTB_ENTRIES];
   logic [CNT_W-1:0]    r_lookups, r_hits, r_misp;

   br_kind_e            w_upd_kind;
   btb_entry_t          w_ent;
   logic                w_hit, w_taken, w_fire;
   logic [XLEN-1:0]     w_target, w_pc_plus4;
   logic [G-1:0]        w_pht_idx;
   logic                w_spec_push, w_spec_pop, w_upd_call, w_upd_ret;
   logic [XLEN-1:0]     w_spec_top, w_com_top;
   logic [PW:0]         w_spec_count, w_com_count, w_com_nxt_count, w_spec_nxt_count;
   logic [PW-1:0]       w_com_nxt_ptr, w_spec_nxt_ptr;
   logic [RAS_DEPTH-1:0][XLEN-1:0] w_com_nxt_entries, w_spec_nxt_entries;
   logic                w_unused;

   assign w_upd_kind = br_kind_e'(upd_kind);
   assign w_ent      = r_btb[r_pc[B+1:2]];
   assign w_hit      = w_ent.valid && (w_ent.tag == r_pc[XLEN-1:B+2]);
   assign w_pht_idx  = r_pc[G+1:2] ^ r_ghr;
   assign w_pc_plus4 = r_pc + XLEN'(4);
   assign w_fire     = r_valid & ~stall & ~redirect_valid;

   always_comb begin
      w_taken  = 1'b0;
      w_target = w_ent.target;
      if (w_hit) begin
         case (w_ent.kind)
            BR_COND: w_taken = r_pht[w_pht_idx][1];
            BR_RET: begin
               w_taken = 1'b1;
               if (w_spec_count != '0) w_target = w_spec_top;
            end
            default: w_taken = 1'b1;
         endcase
      end
   end

   assign w_spec_push = w_fire & w_hit & (w_ent.kind == BR_CALL);
   assign w_spec_pop  = w_fire & w_hit & (w_ent.kind == BR_RET);
   assign w_upd_call  = upd_valid & (w_upd_kind == BR_CALL);
   assign w_upd_ret   = upd_valid & (w_upd_kind == BR_RET);

   ras_stack #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras_commit (
      .clk(clk), .rst_n(rst_n),
      .push(w_upd_call), .pop(w_upd_ret), .push_data(upd_pc + XLEN'(4)),
      .load(1'b0), .load_entries('0), .load_ptr('0), .load_count('0),
      .top(w_com_top), .count(w_com_count),
      .nxt_entries(w_com_nxt_entries), .nxt_ptr(w_com_nxt_ptr), .nxt_count(w_com_nxt_count)
   );

   // Redirect repairs the speculative stack from the committed next state,
   // so a same-cycle committed call/return is already reflected.
   ras_stack #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras_spec (
      .clk(clk), .rst_n(rst_n),
      .push(w_spec_push), .pop(w_spec_pop), .push_data(w_pc_plus4),
      .load(redirect_valid), .load_entries(w_com_nxt_entries),
      .load_ptr(w_com_nxt_ptr), .load_count(w_com_nxt_count),
      .top(w_spec_top), .count(w_spec_count),
      .nxt_entries(w_spec_nxt_entries), .nxt_ptr(w_spec_nxt_ptr), .nxt_count(w_spec_nxt_count)
   );

   assign w_unused = ^{w_com_top, w_com_count, w_spec_nxt_entries, w_spec_nxt_ptr, w_spec_nxt_count};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= RESET_PC;
         r_ghr     <= '0;
         r_lookups <= '0;
         r_hits    <= '0;
         r_misp    <= '0;
         for (int unsigned i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= PHT_RESET;
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) r_btb[i] <= '0;
      end else begin
         r_valid <= 1'b1;
         if (redirect_valid)  r_pc <= redirect_pc;
         else if (w_fire)     r_pc <= w_taken ? w_target : w_pc_plus4;
         if (upd_valid && w_upd_kind == BR_COND) begin
            r_pht[upd_pht_idx] <= sat2(r_pht[upd_pht_idx], upd_taken);
            r_ghr              <= {r_ghr[G-2:0], upd_taken};
         end
         if (upd_valid && upd_taken)
            r_btb[upd_pc[B+1:2]] <= '{valid: 1'b1, tag: upd_pc[XLEN-1:B+2],
                                      target: upd_target, kind: w_upd_kind};
         r_lookups <= r_lookups + CNT_W'(w_fire);
         r_hits    <= r_hits + CNT_W'(w_fire & w_hit);
         r_misp    <= r_misp + CNT_W'(upd_valid & upd_mispredict);
      end
   end

   assign f_valid          = r_valid;
   assign f_pc             = r_pc;
   assign f_pred_taken     = w_taken;
   assign f_pred_target    = w_target;
   assign f_pht_idx        = w_pht_idx;
   assign f_btb_hit        = w_hit;
   assign f_kind           = w_hit ? w_ent.kind : BR_COND;
   assign perf_lookups     = r_lookups;
   assign perf_btb_hits    = r_hits;
   assign perf_mispredicts = r_misp;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench: directed predictor scenarios and random traffic against a
// queue-based reference model of fetch_predict_unit.
module tb_fetch_predict_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        stall = 1'b0, redirect_valid = 1'b0, upd_valid = 1'b0;
   logic        upd_taken = 1'b0, upd_mispredict = 1'b0;
   logic [31:0] redirect_pc = '0, upd_pc = '0, upd_target = '0;
   logic [1:0]  upd_kind = '0;
   logic [7:0]  upd_pht_idx = '0;
   logic        f_valid, f_pred_taken, f_btb_hit;
   logic [31:0] f_pc, f_pred_target;
   logic [7:0]  f_pht_idx;
   logic [1:0]  f_kind;
   logic [63:0] perf_lookups, perf_btb_hits, perf_mispredicts;

   fetch_predict_unit #(
      .XLEN(32), .PHT_ENTRIES(256), .BTB_ENTRIES(64), .RAS_DEPTH(8),
      .RESET_PC(32'h0000_0000), .CNT_W(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_kind(upd_kind), .upd_pht_idx(upd_pht_idx),
      .upd_mispredict(upd_mispredict),
      .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .f_pred_target(f_pred_target), .f_pht_idx(f_pht_idx), .f_btb_hit(f_btb_hit),
      .f_kind(f_kind), .perf_lookups(perf_lookups), .perf_btb_hits(perf_btb_hits),
      .perf_mispredicts(perf_mispredicts)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: plain arrays for tables, queues for the return stacks
   bit          mvalid;
   bit [31:0]   mpc;
   bit [7:0]    mghr;
   bit [1:0]    mpht [256];
   bit          bv [64];
   bit [23:0]   btag [64];
   bit [31:0]   btgt [64];
   bit [1:0]    bkind [64];
   bit [31:0]   sq[$], cq[$];
   bit [63:0]   m_look, m_hits, m_misp;
   bit          e_hit, e_taken;
   bit [1:0]    e_kind;
   bit [7:0]    e_idx;
   bit [31:0]   e_tgt;

   function automatic void model_reset();
      mvalid = 0; mpc = 0; mghr = 0;
      for (int i = 0; i < 256; i++) mpht[i] = 2'd1;
      for (int i = 0; i < 64; i++) begin bv[i] = 0; btag[i] = 0; btgt[i] = 0; bkind[i] = 0; end
      sq.delete(); cq.delete();
      m_look = 0; m_hits = 0; m_misp = 0;
   endfunction

   function automatic void model_pred();
      int bi;
      bi     = (mpc / 4) % 64;
      e_idx  = 8'((mpc / 4) % 256) ^ mghr;
      e_hit  = bv[bi] && (btag[bi] == 24'(mpc / 256));
      e_kind = e_hit ? bkind[bi] : 2'd0;
      e_tgt  = btgt[bi];
      e_taken = 0;
      if (e_hit) begin
         if (e_kind == 2'd0) e_taken = mpht[e_idx] >= 2;
         else e_taken = 1;
         if (e_kind == 2'd3 && sq.size() > 0) e_tgt = sq[$];
      end
   endfunction

   function automatic void model_step();
      bit fire;
      int ui;
      fire = mvalid && !stall && !redirect_valid;
      model_pred();
      if (fire && e_hit && e_kind == 2'd2) begin
         sq.push_back(mpc + 32'd4);
         if (sq.size() > 8) void'(sq.pop_front());
      end else if (fire && e_hit && e_kind == 2'd3 && sq.size() > 0) void'(sq.pop_back());
      if (upd_valid && upd_kind == 2'd2) begin
         cq.push_back(upd_pc + 32'd4);
         if (cq.size() > 8) void'(cq.pop_front());
      end else if (upd_valid && upd_kind == 2'd3 && cq.size() > 0) void'(cq.pop_back());
      if (redirect_valid) sq = cq;
      if (upd_valid && upd_kind == 2'd0) begin
         if (upd_taken && mpht[upd_pht_idx] != 3) mpht[upd_pht_idx]++;
         else if (!upd_taken && mpht[upd_pht_idx] != 0) mpht[upd_pht_idx]--;
         mghr = {mghr[6:0], upd_taken};
      end
      if (upd_valid && upd_taken) begin
         ui = (upd_pc / 4) % 64;
         bv[ui] = 1; btag[ui] = 24'(upd_pc / 256); btgt[ui] = upd_target; bkind[ui] = upd_kind;
      end
      m_look += 64'(fire);
      m_hits += 64'(fire && e_hit);
      m_misp += 64'(upd_valid && upd_mispredict);
      if (redirect_valid) mpc = redirect_pc;
      else if (fire) mpc = e_taken ? e_tgt : mpc + 32'd4;
      mvalid = 1;
   endfunction

   // Starts and ends at posedge+1; outputs compared at the falling edge
   task automatic tick();
      #4;
      model_pred();
      chk("valid", f_valid, mvalid);
      chk("pc", f_pc, mpc);
      chk("btb_hit", f_btb_hit, e_hit);
      chk("kind", f_kind, e_kind);
      chk("pht_idx", f_pht_idx, e_idx);
      chk("pred_taken", f_pred_taken, e_taken);
      if (e_taken) chk("pred_target", f_pred_target, e_tgt);
      chk("lookups", perf_lookups, m_look);
      chk("btb_hits", perf_btb_hits, m_hits);
      chk("mispredicts", perf_mispredicts, m_misp);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [1:0] kind, input logic [7:0] idx);
      upd_valid = 1; upd_pc = pc; upd_target = tgt; upd_taken = 1;
      upd_kind = kind; upd_pht_idx = idx; upd_mispredict = 1;
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; upd_valid = 0; upd_mispredict = 0; upd_taken = 0;
   endtask

   task automatic rand_inputs();
      stall          = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc    = $urandom_range(0, 127) * 4;
      upd_valid      = ($urandom % 2) == 1;
      upd_pc         = $urandom_range(0, 127) * 4;
      upd_target     = $urandom_range(0, 127) * 4;
      upd_taken      = ($urandom % 2) == 1;
      upd_kind       = 2'($urandom % 4);
      upd_pht_idx    = 8'($urandom);
      upd_mispredict = ($urandom % 2) == 1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"}, f_valid, 0);
      chk({tag, "_pc"}, f_pc, 0);
      chk({tag, "_hit"}, f_btb_hit, 0);
      chk({tag, "_taken"}, f_pred_taken, 0);
      chk({tag, "_kind"}, f_kind, 0);
      chk({tag, "_idx"}, f_pht_idx, 0);
      chk({tag, "_lookups"}, perf_lookups, 0);
      chk({tag, "_hits"}, perf_btb_hits, 0);
      chk({tag, "_misp"}, perf_mispredicts, 0);
      chk({tag, "_noX"}, 64'($isunknown({f_valid, f_pc, f_pred_taken, f_pred_target, f_pht_idx,
          f_btb_hit, f_kind, perf_lookups, perf_btb_hits, perf_mispredicts})), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int guard;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst");
      rst_n = 1;
      tick();
      chk("first_valid", f_valid, 1);
      chk("first_pc", f_pc, 32'h0);
      tick();
      chk("second_pc", f_pc, 32'h4);

      // loop branch 0x40 -> 0x20; redirect wins over stall
      stall = 1; redirect_valid = 1; redirect_pc = 32'h40; tick(); redirect_valid = 0;
      chk("redir_over_stall", f_pc, 32'h40);
      set_upd(32'h40, 32'h20, 2'd0, 8'h13); tick(); upd_valid = 0;
      chk("loop_hit", f_btb_hit, 1);
      chk("loop_not_taken_weak", f_pred_taken, 0);
      set_upd(32'h40, 32'h20, 2'd0, 8'h13); tick(); upd_valid = 0;
      chk("loop_taken", f_pred_taken, 1);
      chk("loop_target", f_pred_target, 32'h20);
      stall = 0; tick();
      chk("loop_jump", f_pc, 32'h20);
      chk("loop_btb_hits", perf_btb_hits, 1);

      // call 0x100 -> 0x800, return at 0x810
      stall = 1;
      set_upd(32'h100, 32'h800, 2'd2, 8'h0); tick();
      set_upd(32'h810, 32'h7F0, 2'd3, 8'h0); tick(); upd_valid = 0;
      stall = 0; redirect_valid = 1; redirect_pc = 32'h100; tick(); redirect_valid = 0;
      chk("call_kind", f_kind, 2);
      tick();
      chk("call_jump", f_pc, 32'h800);
      repeat (4) tick();
      chk("ret_pc", f_pc, 32'h810);
      chk("ret_target", f_pred_target, 32'h104);
      tick();
      chk("ret_return", f_pc, 32'h104);
      stall = 1; redirect_valid = 1; redirect_pc = 32'h810; tick(); redirect_valid = 0;
      chk("ret_underflow_taken", f_pred_taken, 1);
      chk("ret_underflow_target", f_pred_target, 32'h7F0);

      // stall + redirect with a same-cycle committed call
      redirect_valid = 1; redirect_pc = 32'h810;
      set_upd(32'h600, 32'h900, 2'd2, 8'h0); tick(); upd_valid = 0; redirect_valid = 0;
      chk("redir_repair_top", f_pred_target, 32'h604);
      stall = 0; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 0;
      tick();
      chk("pc_wrap", f_pc, 32'h0);

      // RAS_DEPTH+1 chained calls, then RAS_DEPTH+1 returns
      stall = 1;
      for (int k = 0; k < 9; k++) begin
         set_upd(32'h300 + 32'(8 * k), (k == 8) ? 32'h380 : 32'h308 + 32'(8 * k), 2'd2, 8'h0);
         tick();
      end
      set_upd(32'h380, 32'h500, 2'd3, 8'h0); tick();
      for (int k = 0; k < 9; k++) begin
         set_upd(32'h304 + 32'(8 * k), 32'h500, 2'd3, 8'h0); tick();
      end
      upd_valid = 0; stall = 0; redirect_valid = 1; redirect_pc = 32'h300; tick();
      redirect_valid = 0;
      for (guard = 0; guard < 60 && mpc != 32'h30C; guard++) tick();
      chk("chain_reach", f_pc, 32'h30C);
      chk("chain_fallback_taken", f_pred_taken, 1);
      chk("chain_fallback_target", f_pred_target, 32'h500);

      // random traffic with an asynchronous reset in the middle
      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         tick();
         if (i == 700) begin
            #3;
            rst_n = 0;
            #1;
            check_reset_state("midrst");
            idle();
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1;
         end
      end
      idle();
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
